branch_predictor: RTL and testbench

Fetch-stage next-PC predictor. It decodes the raw fetched word (RV32I and RV32C), computes the sequential or jump target, and predicts conditional branches from a table of saturating counters. The table is indexed by PC and trained by the resolution port from the execute/commit side. It sits between the instruction fetch unit and the I-cache request path and replaces the purely combinational next-PC calculator.

---
 rtl/branch_predictor_if.sv | 39 +++
 rtl/branch_predictor.sv | 128 ++++++++++++
 tb/tb_branch_predictor.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and execute-side training signals
// shared by the fetch unit and the next-PC predictor.
interface branch_predictor_if #(
  parameter int BHT_IDX_W = 6
);
  logic [31:0]          pc_in;
  logic [31:0]          inst_in;
  logic [31:0]          next_pc;
  logic                 pred_taken;
  logic                 is_cond_br;
  logic [BHT_IDX_W-1:0] pred_idx;
  logic                 upd_valid;
  logic [BHT_IDX_W-1:0] upd_idx;
  logic                 upd_taken;

  modport master (
    output pc_in,
    output inst_in,
    output upd_valid,
    output upd_idx,
    output upd_taken,
    input  next_pc,
    input  pred_taken,
    input  is_cond_br,
    input  pred_idx
  );

  modport slave (
    input  pc_in,
    input  inst_in,
    input  upd_valid,
    input  upd_idx,
    input  upd_taken,
    output next_pc,
    output pred_taken,
    output is_cond_br,
    output pred_idx
  );
endinterface

// File: rtl/branch_predictor.sv
// Fetch next-PC predictor: RV32I/RV32C decode plus counter table.
// Define BP_GSHARE_EN to fold global history into the index.
module branch_predictor #(
  parameter int BHT_IDX_W = 6,
  parameter int CNT_W     = 2
) (
  input logic               clk_in,
  input logic               rst_in,
  input logic               rdy_in,
  branch_predictor_if.slave bp
);
  localparam int DEPTH = 1 << BHT_IDX_W;
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]     cnt_q [DEPTH];
  logic [CNT_W-1:0]     cnt_d;
  logic [CNT_W-1:0]     cnt_cur;
  logic [BHT_IDX_W-1:0] lk_idx;
  logic                 lk_taken;

`ifdef BP_GSHARE_EN
  logic [BHT_IDX_W-1:0] ghr_q;
  logic [BHT_IDX_W-1:0] ghr_d;

  assign lk_idx = bp.pc_in[BHT_IDX_W:1] ^ ghr_q;
  assign ghr_d  = {ghr_q[BHT_IDX_W-2:0], bp.upd_taken};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ghr_q <= '0;
    end else if (rdy_in && bp.upd_valid) begin
      ghr_q <= ghr_d;
    end
  end
`else
  assign lk_idx = bp.pc_in[BHT_IDX_W:1];
`endif

  assign lk_taken    = cnt_q[lk_idx][CNT_W-1];
  assign bp.pred_idx = lk_idx;

  assign cnt_cur = cnt_q[bp.upd_idx];

  always_comb begin
    cnt_d = cnt_cur;
    if (bp.upd_taken) begin
      if (cnt_cur != CNT_MAX) cnt_d = cnt_cur + CNT_W'(1);
    end else begin
      if (cnt_cur != '0) cnt_d = cnt_cur - CNT_W'(1);
    end
  end

  // Reset wins over a same-cycle training strobe.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= CNT_INIT;
      end
    end else if (rdy_in && bp.upd_valid) begin
      cnt_q[bp.upd_idx] <= cnt_d;
    end
  end

  logic [31:0] ins;
  logic [2:0]  f3;
  logic        len4;
  logic        is_jal;
  logic        is_br;
  logic        is_cj;
  logic        is_cb;
  logic [31:0] seq_pc;
  logic [31:0] imm_j;
  logic [31:0] imm_b;
  logic [31:0] imm_cj;
  logic [31:0] imm_cb;

  assign ins  = bp.inst_in;
  assign f3   = ins[15:13];
  assign len4 = ins[1:0] == 2'b11;

  assign is_jal = len4 && ins[6:0] == 7'b1101111;
  assign is_br  = len4 && ins[6:0] == 7'b1100011;
  assign is_cj  = ins[1:0] == 2'b01 &&
                  (f3 == 3'b101 || f3 == 3'b001);
  assign is_cb  = ins[1:0] == 2'b01 &&
                  (f3 == 3'b110 || f3 == 3'b111);

  assign seq_pc = bp.pc_in + (len4 ? 32'd4 : 32'd2);

  assign imm_j  = {{11{ins[31]}}, ins[31], ins[19:12],
                   ins[20], ins[30:21], 1'b0};
  assign imm_b  = {{19{ins[31]}}, ins[31], ins[7],
                   ins[30:25], ins[11:8], 1'b0};
  assign imm_cj = {{20{ins[12]}}, ins[12], ins[8],
                   ins[10:9], ins[6], ins[7], ins[2],
                   ins[11], ins[5:3], 1'b0};
  assign imm_cb = {{23{ins[12]}}, ins[12], ins[6:5],
                   ins[2], ins[11:10], ins[4:3], 1'b0};

  always_comb begin
    bp.next_pc    = seq_pc;
    bp.pred_taken = 1'b0;
    bp.is_cond_br = 1'b0;
    unique case (1'b1)
      is_jal: begin
        bp.next_pc    = bp.pc_in + imm_j;
        bp.pred_taken = 1'b1;
      end
      is_cj: begin
        bp.next_pc    = bp.pc_in + imm_cj;
        bp.pred_taken = 1'b1;
      end
      is_br: begin
        bp.is_cond_br = 1'b1;
        bp.pred_taken = lk_taken;
        if (lk_taken) bp.next_pc = bp.pc_in + imm_b;
      end
      is_cb: begin
        bp.is_cond_br = 1'b1;
        bp.pred_taken = lk_taken;
        if (lk_taken) bp.next_pc = bp.pc_in + imm_cb;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: decode table
// plus counter training, reset and same-cycle sequences.
module tb_branch_predictor;
  logic clk;
  logic rst;
  logic rdy;

  branch_predictor_if #(.BHT_IDX_W(6)) bp ();

  branch_predictor #(
    .BHT_IDX_W(6),
    .CNT_W    (2)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .rdy_in(rdy),
    .bp    (bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] npc;
    logic        tk;
    logic        cb;
    logic [5:0]  idx;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[12];
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [31:0] BEQ40 = 32'h0400_0063;
  localparam logic [31:0] CBNEZ = 32'h0000_FC75;

  task automatic chk(input string nm,
                     input logic [31:0] pc,
                     input logic [31:0] inst,
                     input logic [31:0] npc,
                     input logic tk,
                     input logic cb,
                     input logic [5:0] idx);
    vec_t e;
    e = '{nm, pc, inst, npc, tk, cb, idx};
    bp.pc_in   = pc;
    bp.inst_in = inst;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (bp.next_pc !== e.npc || bp.pred_taken !== e.tk ||
        bp.is_cond_br !== e.cb || bp.pred_idx !== e.idx) begin
      n_err++;
      $display("FAIL %s: got npc=%h tk=%b cb=%b idx=%h want npc=%h tk=%b cb=%b idx=%h",
               e.nm, bp.next_pc, bp.pred_taken, bp.is_cond_br,
               bp.pred_idx, e.npc, e.tk, e.cb, e.idx);
    end
  endtask

  task automatic upd(input logic [5:0] idx,
                     input logic tk,
                     input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bp.upd_valid = 1'b1;
      bp.upd_idx   = idx;
      bp.upd_taken = tk;
    end
    @(negedge clk);
    bp.upd_valid = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{"beq_rst", 32'h100, BEQ40,
                32'h104, 1'b0, 1'b1, 6'h00};
    tbl[1]  = '{"jal_m8", 32'h200, 32'hFF9F_F06F,
                32'h1F8, 1'b1, 1'b0, 6'h00};
    tbl[2]  = '{"cj_p10", 32'h202, 32'h0000_A801,
                32'h212, 1'b1, 1'b0, 6'h01};
    tbl[3]  = '{"cjal_p10", 32'h202, 32'h0000_2801,
                32'h212, 1'b1, 1'b0, 6'h01};
    tbl[4]  = '{"jalr", 32'h300, 32'h0000_8067,
                32'h304, 1'b0, 1'b0, 6'h00};
    tbl[5]  = '{"cbnez_nt", 32'h1002, CBNEZ,
                32'h1004, 1'b0, 1'b1, 6'h01};
    tbl[6]  = '{"addi", 32'h10, 32'h0000_0013,
                32'h14, 1'b0, 1'b0, 6'h08};
    tbl[7]  = '{"cnop", 32'h7E, 32'h0000_0001,
                32'h80, 1'b0, 1'b0, 6'h3F};
    tbl[8]  = '{"cjr", 32'h40, 32'h0000_8082,
                32'h42, 1'b0, 1'b0, 6'h20};
    tbl[9]  = '{"jal_wrap", 32'hFFFF_FFFC, 32'hFF9F_F06F,
                32'hFFFF_FFF4, 1'b1, 1'b0, 6'h3E};
    tbl[10] = '{"beq_wrap", 32'hFFFF_FFFC, BEQ40,
                32'h0, 1'b0, 1'b1, 6'h3E};
    tbl[11] = '{"cbeqz_nt", 32'h2000, 32'h0000_DC75,
                32'h2002, 1'b0, 1'b1, 6'h00};

    rst          = 1'b1;
    rdy          = 1'b1;
    bp.pc_in     = '0;
    bp.inst_in   = '0;
    bp.upd_valid = 1'b0;
    bp.upd_idx   = '0;
    bp.upd_taken = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      chk(tbl[i].nm, tbl[i].pc, tbl[i].inst,
          tbl[i].npc, tbl[i].tk, tbl[i].cb, tbl[i].idx);
    end

`ifdef BP_GSHARE_EN
    upd(6'h00, 1'b1, 1);
    upd(6'h00, 1'b0, 1);
    upd(6'h00, 1'b1, 1);
    chk("gs_idx5", 32'h100, BEQ40,
        32'h104, 1'b0, 1'b1, 6'h05);
    chk("gs_idx0", 32'h10A, BEQ40,
        32'h14A, 1'b1, 1'b1, 6'h00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("gs_rst", 32'h100, BEQ40,
        32'h104, 1'b0, 1'b1, 6'h00);
`else
    upd(6'h00, 1'b1, 1);
    chk("tr_1", 32'h100, BEQ40,
        32'h140, 1'b1, 1'b1, 6'h00);
    upd(6'h00, 1'b1, 4);
    chk("tr_sat3", 32'h100, BEQ40,
        32'h140, 1'b1, 1'b1, 6'h00);
    upd(6'h00, 1'b0, 1);
    chk("tr_nt1", 32'h100, BEQ40,
        32'h140, 1'b1, 1'b1, 6'h00);
    upd(6'h00, 1'b0, 3);
    upd(6'h00, 1'b1, 1);
    chk("tr_lo1", 32'h100, BEQ40,
        32'h104, 1'b0, 1'b1, 6'h00);
    upd(6'h00, 1'b1, 1);
    chk("tr_lo2", 32'h100, BEQ40,
        32'h140, 1'b1, 1'b1, 6'h00);

    upd(6'h01, 1'b1, 1);
    chk("cbnez_tk", 32'h1002, CBNEZ,
        32'hFFE, 1'b1, 1'b1, 6'h01);

    @(negedge clk);
    rst          = 1'b1;
    bp.upd_valid = 1'b1;
    bp.upd_idx   = 6'h00;
    bp.upd_taken = 1'b1;
    chk("rst_preclr", 32'h1002, CBNEZ,
        32'hFFE, 1'b1, 1'b1, 6'h01);
    @(negedge clk);
    rst          = 1'b0;
    bp.upd_valid = 1'b0;
    chk("rst_idx1", 32'h1002, CBNEZ,
        32'h1004, 1'b0, 1'b1, 6'h01);
    chk("rst_prio", 32'h100, BEQ40,
        32'h104, 1'b0, 1'b1, 6'h00);

    rdy = 1'b0;
    upd(6'h00, 1'b1, 2);
    rdy = 1'b1;
    chk("rdy_drop", 32'h100, BEQ40,
        32'h104, 1'b0, 1'b1, 6'h00);

    @(negedge clk);
    bp.upd_valid = 1'b1;
    bp.upd_idx   = 6'h00;
    bp.upd_taken = 1'b1;
    chk("same_old", 32'h100, BEQ40,
        32'h104, 1'b0, 1'b1, 6'h00);
    @(posedge clk);
    #1;
    bp.upd_valid = 1'b0;
    chk("same_new", 32'h100, BEQ40,
        32'h140, 1'b1, 1'b1, 6'h00);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
